eep_arb_ctrl: RTL and testbench

Sequences all accesses to the 4-word x 12-bit calibration EEPROM and shares it between two requesters. Requester 0 is the SPI command path in dig_core. Requester 1 is the power-up calibration loader. Generates eep_addr, eep_cs_n, eep_r_w_n, the write data bus (dst) and the 3 ms charge-pump window, so dig_core no longer times EEPROM writes itself.

---
 rtl/eep_arb_if.sv | 41 ++++
 rtl/eep_arb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_eep_arb_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eep_arb_if.sv
// Requester and EEPROM signal bundle for eep_arb_ctrl.
// Handshake: reqN is a level held until doneN; gntN/doneN are one-cycle pulses; requester inputs are sampled only in the grant.
interface eep_arb_if;
    logic        req0;
    logic        req0_wr;
    logic [1:0]  req0_addr;
    logic [11:0] req0_wdata;
    logic        req1;
    logic        req1_wr;
    logic [1:0]  req1_addr;
    logic [11:0] req1_wdata;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [11:0] rd_data;
    logic        busy;
    logic        wr_err;
    logic [11:0] eep_rd_data;
    logic [1:0]  eep_addr;
    logic        eep_cs_n;
    logic        eep_r_w_n;
    logic [11:0] dst;
    logic        chrg_pmp_en;

    modport slave (
        input  req0, req0_wr, req0_addr, req0_wdata,
        input  req1, req1_wr, req1_addr, req1_wdata,
        input  eep_rd_data,
        output gnt0, gnt1, done0, done1, rd_data, busy, wr_err,
        output eep_addr, eep_cs_n, eep_r_w_n, dst, chrg_pmp_en
    );

    modport master (
        output req0, req0_wr, req0_addr, req0_wdata,
        output req1, req1_wr, req1_addr, req1_wdata,
        output eep_rd_data,
        input  gnt0, gnt1, done0, done1, rd_data, busy, wr_err,
        input  eep_addr, eep_cs_n, eep_r_w_n, dst, chrg_pmp_en
    );
endinterface

// File: rtl/eep_arb_ctrl.sv
// Round-robin arbiter and access sequencer for the 4x12 calibration EEPROM, including the charge-pump write window.
// Optional write read-back verify is enabled with `define EEP_WR_VERIFY_EN.
module eep_arb_ctrl #(
    parameter int unsigned CP_CYCLES = 1500000,
    parameter int unsigned RD_WAIT   = 2,
    parameter int unsigned CPW       = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    eep_arb_if.slave   bus,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_GNT, S_RD, S_WR_SU, S_WR_PMP, S_WR_HLD, S_VRFY_RD, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CPW-1:0]   cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             owner_q, owner_d;
    logic [1:0]       addr_q, addr_d;
    logic [11:0]      dst_q, dst_d;
    logic [11:0]      rd_data_q, rd_data_d;
    logic             gnt0_q, gnt1_q, done0_q, done1_q;
    logic             cs_n_q, r_w_n_q, pmp_q, busy_q;
`ifdef EEP_WR_VERIFY_EN
    logic             wr_err_q, wr_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        dst_d     = dst_q;
        rd_data_d = rd_data_q;
`ifdef EEP_WR_VERIFY_EN
        wr_err_d  = wr_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester not granted last wins
                    owner_d = (bus.req0 && bus.req1) ? ~owner_q : bus.req1;
                    wr_d    = owner_d ? bus.req1_wr    : bus.req0_wr;
                    addr_d  = owner_d ? bus.req1_addr  : bus.req0_addr;
                    dst_d   = owner_d ? bus.req1_wdata : bus.req0_wdata;
`ifdef EEP_WR_VERIFY_EN
                    wr_err_d = 1'b0;
`endif
                    state_d = S_GNT;
                end
            end
            S_GNT: begin
                if (wr_q) begin
                    state_d = S_WR_SU;
                end else begin
                    cnt_d   = CPW'(RD_WAIT);
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == CPW'(1)) begin
                    rd_data_d = bus.eep_rd_data;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - CPW'(1);
                end
            end
            S_WR_SU: begin
                cnt_d   = CPW'(CP_CYCLES);
                state_d = S_WR_PMP;
            end
            S_WR_PMP: begin
                if (cnt_q == CPW'(1)) begin
                    state_d = S_WR_HLD;
                end else begin
                    cnt_d = cnt_q - CPW'(1);
                end
            end
            S_WR_HLD: begin
`ifdef EEP_WR_VERIFY_EN
                cnt_d   = CPW'(RD_WAIT);
                state_d = S_VRFY_RD;
`else
                state_d = S_DONE;
`endif
            end
`ifdef EEP_WR_VERIFY_EN
            S_VRFY_RD: begin
                if (cnt_q == CPW'(1)) begin
                    rd_data_d = bus.eep_rd_data;
                    wr_err_d  = (bus.eep_rd_data != dst_q);
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - CPW'(1);
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered decodes of the next state, so they line up with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            owner_q   <= 1'b1;
            addr_q    <= 2'd0;
            dst_q     <= 12'd0;
            rd_data_q <= 12'd0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            r_w_n_q   <= 1'b1;
            pmp_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            dst_q     <= dst_d;
            rd_data_q <= rd_data_d;
            gnt0_q    <= (state_d == S_GNT)  && !owner_d;
            gnt1_q    <= (state_d == S_GNT)  &&  owner_d;
            done0_q   <= (state_d == S_DONE) && !owner_d;
            done1_q   <= (state_d == S_DONE) &&  owner_d;
            cs_n_q    <= !(state_d inside {S_RD, S_WR_SU, S_WR_PMP, S_WR_HLD, S_VRFY_RD});
            r_w_n_q   <= !(state_d inside {S_WR_SU, S_WR_PMP, S_WR_HLD});
            pmp_q     <= (state_d == S_WR_PMP);
            busy_q    <= (state_d != S_IDLE);
        end
    end

`ifdef EEP_WR_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end
    assign bus.wr_err = wr_err_q;
`else
    assign bus.wr_err = 1'b0;
`endif

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.busy        = busy_q;
    assign bus.eep_addr    = addr_q;
    assign bus.eep_cs_n    = cs_n_q;
    assign bus.eep_r_w_n   = r_w_n_q;
    assign bus.dst         = dst_q;
    assign bus.chrg_pmp_en = pmp_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_eep_arb_ctrl.sv
// Directed bench for eep_arb_ctrl with a behavioural EEPROM and a done-ordered scoreboard.
module tb_eep_arb_ctrl;
  localparam int CP  = 10;
  localparam int RDW = 2;
`ifdef EEP_WR_VERIFY_EN
  localparam int WR_LAT = CP + RDW + 3;
`else
  localparam int WR_LAT = CP + 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  dbg_state;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_busy = 1'b0;
  logic [13:0] exp_q[$];
  logic [13:0] sb_e;
  logic [11:0] mem [4] = '{12'h111, 12'h222, 12'hA5C, 12'h444};

  eep_arb_if bus();

  eep_arb_ctrl #(.CP_CYCLES(CP), .RD_WAIT(RDW), .CPW(21)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // EEPROM model: written while the pump runs, read data driven only while selected
  always @(posedge clk) begin
    if (!bus.eep_cs_n && !bus.eep_r_w_n && bus.chrg_pmp_en)
`ifdef EEP_WR_VERIFY_EN
      mem[bus.eep_addr] <= (bus.dst == 12'h001) ? 12'h000 : bus.dst;
`else
      mem[bus.eep_addr] <= bus.dst;
`endif
  end
  assign bus.eep_rd_data = bus.eep_cs_n ? 12'h000 : mem[bus.eep_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: entry = {requester, is_read, word}
  always @(negedge clk) begin
    if (bus.gnt0 || bus.gnt1) chk("gnt_after_idle", 32'(prev_busy), 32'd0);
    if (bus.done0 || bus.done1) begin
      chk("done_onehot", 32'(bus.done0 & bus.done1), 32'd0);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk("done_who", 32'(bus.done1), 32'(sb_e[13]));
        if (sb_e[12]) chk("rd_data", 32'(bus.rd_data), 32'(sb_e[11:0]));
        else          chk("wr_dst", 32'(bus.dst), 32'(sb_e[11:0]));
      end
    end
    if (bus.chrg_pmp_en) chk("pmp_rwn_cs", 32'({bus.eep_r_w_n, bus.eep_cs_n}), 32'd0);
    prev_busy = bus.busy;
  end

  // driver tasks
  task automatic drive(input bit who, input bit wr, input logic [1:0] addr, input logic [11:0] wd);
    if (who) begin
      bus.req1 = 1'b1; bus.req1_wr = wr; bus.req1_addr = addr; bus.req1_wdata = wd;
    end else begin
      bus.req0 = 1'b1; bus.req0_wr = wr; bus.req0_addr = addr; bus.req0_wdata = wd;
    end
  endtask

  task automatic wait_gnt(input bit who, output int t);
    bit seen = 1'b0;
    t = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((who ? bus.gnt1 : bus.gnt0) == 1'b1) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    chk(who ? "gnt1_seen" : "gnt0_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input bit who, output int t);
    bit seen = 1'b0;
    t = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if ((who ? bus.done1 : bus.done0) == 1'b1) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    chk(who ? "done1_seen" : "done0_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "bench stopped");
  end

  initial begin
    int tg, td, t0, t1, t2, pmp_cnt, rwn_low;
    bit seen;
    bus.req0 = 1'b0; bus.req0_wr = 1'b0; bus.req0_addr = 2'd0; bus.req0_wdata = 12'd0;
    bus.req1 = 1'b0; bus.req1_wr = 1'b0; bus.req1_addr = 2'd0; bus.req1_wdata = 12'd0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_rwn_pmp", 32'({bus.eep_cs_n, bus.eep_r_w_n, bus.chrg_pmp_en}), 32'b110);
    chk("rst_addr_dst", 32'({bus.eep_addr, bus.dst}), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_pulses_busy_err",
        32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.wr_err}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single read from requester 0
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b1, 12'hA5C});
    drive(1'b0, 1'b0, 2'd2, 12'h000);
    wait_gnt(1'b0, tg);
    bus.req0 = 1'b0;
    chk("rd_gnt_cs_high", 32'(bus.eep_cs_n), 32'd1);
    for (int i = 0; i < RDW; i++) begin
      @(negedge clk);
      chk("rd_cs_low", 32'({bus.eep_cs_n, bus.eep_r_w_n}), 32'b01);
    end
    wait_done(1'b0, td);
    chk("rd_latency", 32'(td - tg), 32'(RDW + 1));
    chk("rd_done_cs_high", 32'(bus.eep_cs_n), 32'd1);

    // single write from requester 1
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b0, 12'h3F0});
    drive(1'b1, 1'b1, 2'd1, 12'h3F0);
    wait_gnt(1'b1, tg);
    bus.req1 = 1'b0;
    pmp_cnt = 0; rwn_low = 0; seen = 1'b0; td = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.chrg_pmp_en) pmp_cnt++;
      if (!bus.eep_r_w_n) rwn_low++;
      if (bus.done1) begin seen = 1'b1; td = cyc; end
    end
    chk("wr_done_seen", 32'(seen), 32'd1);
    chk("wr_pmp_len", 32'(pmp_cnt), 32'(CP));
    chk("wr_rwn_low_len", 32'(rwn_low), 32'(CP + 2));
    chk("wr_latency", 32'(td - tg), 32'(WR_LAT));
    chk("wr_err_clean", 32'(bus.wr_err), 32'd0);
    chk("wr_mem", 32'(mem[1]), 32'h3F0);

    // simultaneous reads held across three accesses: 0,1,0
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b1, 12'h111});
    exp_q.push_back({1'b1, 1'b1, 12'h444});
    exp_q.push_back({1'b0, 1'b1, 12'h111});
    drive(1'b0, 1'b0, 2'd0, 12'h000);
    drive(1'b1, 1'b0, 2'd3, 12'h000);
    wait_gnt(1'b0, t0);
    wait_gnt(1'b1, t1);
    wait_gnt(1'b0, t2);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_done(1'b0, td);
    chk("rr_spacing_01", 32'(t1 - t0), 32'(RDW + 3));
    chk("rr_spacing_10", 32'(t2 - t1), 32'(RDW + 3));

    // reset 4 cycles into the pump window
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'd3, 12'h777);
    wait_gnt(1'b0, tg);
    bus.req0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.chrg_pmp_en) seen = 1'b1;
    end
    chk("pmp_started", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pmp_busy_cs", 32'({bus.chrg_pmp_en, bus.busy, bus.eep_cs_n}), 32'b001);
    chk("arst_rwn_done", 32'({bus.eep_r_w_n, bus.done0, bus.done1}), 32'b100);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (CP + 6) @(negedge clk);
    chk("after_abort_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b1, 12'h3F0});
    drive(1'b1, 1'b0, 2'd1, 12'h000);
    wait_gnt(1'b1, tg);
    bus.req1 = 1'b0;
    wait_done(1'b1, td);
    chk("post_rst_rd_latency", 32'(td - tg), 32'(RDW + 1));

    // write whose request drops the cycle after the grant
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b0, 12'h5A5});
    drive(1'b0, 1'b1, 2'd0, 12'h5A5);
    wait_gnt(1'b0, tg);
    @(posedge clk); #1 bus.req0 = 1'b0;
    wait_done(1'b0, td);
    chk("drop_wr_latency", 32'(td - tg), 32'(WR_LAT));
    chk("drop_wr_mem", 32'(mem[0]), 32'h5A5);

`ifdef EEP_WR_VERIFY_EN
    // read-back verify: corrupted write flags, clean write clears
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b0, 12'h001});
    drive(1'b1, 1'b1, 2'd2, 12'h001);
    wait_gnt(1'b1, tg);
    bus.req1 = 1'b0;
    wait_done(1'b1, td);
    chk("vrfy_err_set", 32'(bus.wr_err), 32'd1);
    chk("vrfy_readback", 32'(bus.rd_data), 32'h000);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b0, 12'h002});
    drive(1'b0, 1'b1, 2'd2, 12'h002);
    wait_gnt(1'b0, tg);
    bus.req0 = 1'b0;
    chk("vrfy_err_clr_gnt", 32'(bus.wr_err), 32'd0);
    wait_done(1'b0, td);
    chk("vrfy_err_clean", 32'(bus.wr_err), 32'd0);
    chk("vrfy_readback_ok", 32'(bus.rd_data), 32'h002);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
